// File: rtl/gshare_predictor.sv
// gshare branch direction predictor.
// The fetch PC is XORed with the low global-history bits to index a table of
// 2-bit saturating counters. Each prediction is registered, so it appears one
// cycle after the request. Resolved branches train the table through the
// update port. After reset, a small FSM clears the table to weakly-not-taken,
// one entry per cycle.
module gshare_predictor #(
    parameter int HISTORY_SIZE = 64,
    parameter int INDEX_BITS   = 8,
    parameter int PC_LSB       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HISTORY_SIZE-1:0] history,
    input  logic                  req_valid,
    input  logic [31:0]           req_pc,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_taken,
    output logic                  ready
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t                state;
    logic [INDEX_BITS-1:0] init_ptr;
    logic [1:0]            pht [ENTRIES];

    logic [INDEX_BITS-1:0] hist_p0;
    logic [INDEX_BITS-1:0] idx_p0;
    logic [1:0]            ctr_p0;

    // Only some PC and history bits feed the index. This fold keeps the
    // remaining bits formally consumed.
    logic unused_inputs;
    assign unused_inputs = ^{req_pc, history};

    // Saturating 2-bit counter step: 00 strongly-NT .. 11 strongly-T.
    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
        end
        return nxt;
    endfunction

    // ---- stage p0: combinational index and table read ----
    generate
        if (HISTORY_SIZE >= INDEX_BITS) begin : g_hist_trunc
            assign hist_p0 = history[INDEX_BITS-1:0];
        end else begin : g_hist_zext
            assign hist_p0 = {{(INDEX_BITS-HISTORY_SIZE){1'b0}}, history};
        end
    endgenerate

    assign idx_p0 = req_pc[PC_LSB +: INDEX_BITS] ^ hist_p0;
    assign ctr_p0 = pht[idx_p0];

    // Clear FSM: walks init_ptr across the table, then holds in READY until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + INDEX_BITS'(1);
                    if (&init_ptr) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Table write port: the clear sweep during INIT, training updates in READY.
    // The table itself is not reset. The clear sweep initialises it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                pht[init_ptr] <= 2'b01;
            end else if (upd_valid) begin
                pht[upd_index] <= sat_next(pht[upd_index], upd_taken);
            end
        end
    end

    // ---- stage p1: registered prediction (reads the pre-update counter) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else if (state == READY) begin
            pred_valid <= req_valid;
            pred_taken <= req_valid & ctr_p0[1];
            if (req_valid) begin
                pred_index <= idx_p0;
            end
        end else begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: init timing, indexing, counter
// saturation, same-cycle predict/update ordering and reset mid-operation.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] history;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic        upd_taken;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    gshare_predictor #(
        .HISTORY_SIZE(64),
        .INDEX_BITS  (8),
        .PC_LSB      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .history   (history),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_index(pred_index),
        .upd_valid (upd_valid),
        .upd_index (upd_index),
        .upd_taken (upd_taken),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle prediction request.
    task automatic do_req(input logic [31:0] pc, input logic [63:0] h);
        req_valid = 1'b1;
        req_pc    = pc;
        history   = h;
        tick();
        req_valid = 1'b0;
    endtask

    // One-cycle training update.
    task automatic do_upd(input logic [7:0] idx, input logic t);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = t;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1; req_pc = 32'h0040_0010; history = 64'h0;
        upd_valid = 1'b0; upd_index = 8'h0; upd_taken = 1'b0;
        tick();
        tick();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", ready); end
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL reset_pred_valid got=%0b exp=0", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_index !== 8'h00) begin failures++; $display("FAIL reset_pred_index got=%0h exp=0", pred_index); end
    endtask

    // Requests every cycle plus taken updates to 0x10 throughout INIT.
    task automatic test_init_timing();
        rst = 1'b0;
        req_valid = 1'b1; req_pc = 32'h0040_0010; history = 64'h0;
        upd_valid = 1'b1; upd_index = 8'h10; upd_taken = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            checks++;
            if (ready !== (k == 256)) begin
                failures++; $display("FAIL init_ready cycle=%0d got=%0b exp=%0b", k, ready, (k == 256));
            end
            checks++;
            if (pred_valid !== 1'b0) begin
                failures++; $display("FAIL init_pred_valid cycle=%0d got=%0b exp=0", k, pred_valid);
            end
        end
        upd_valid = 1'b0;
        tick();
        checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL first_pred_valid got=%0b exp=1", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL first_pred_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_index !== 8'h04) begin failures++; $display("FAIL first_pred_index got=%0h exp=04", pred_index); end
        req_valid = 1'b0;
    endtask

    task automatic test_indexing();
        do_req(32'h0040_0010, 64'hFF);
        checks++; if (pred_index !== 8'hFB) begin failures++; $display("FAIL idx_hist_ff got=%0h exp=fb", pred_index); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL idx_hist_ff_taken got=%0b exp=0", pred_taken); end
        // Upper history bits must not affect the index.
        do_req(32'h0040_0010, 64'hA5A5_0000_0000_0F00);
        checks++; if (pred_index !== 8'h04) begin failures++; $display("FAIL idx_hist_upper got=%0h exp=04", pred_index); end
    endtask

    task automatic test_init_updates();
        do_req(32'h0000_0040, 64'h0);
        checks++; if (pred_index !== 8'h10) begin failures++; $display("FAIL init_upd_index got=%0h exp=10", pred_index); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL init_upd_taken got=%0b exp=0", pred_taken); end
    endtask

    task automatic test_saturation();
        do_upd(8'h04, 1'b1);                       // 01 -> 10
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_t1 got=%0b exp=1", pred_taken); end
        do_upd(8'h04, 1'b1);                       // 10 -> 11
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_t2 got=%0b exp=1", pred_taken); end
        do_upd(8'h04, 1'b0);                       // 11 -> 10
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_nt1 got=%0b exp=1", pred_taken); end
        do_upd(8'h04, 1'b0);                       // 10 -> 01
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_nt2 got=%0b exp=0", pred_taken); end
        do_upd(8'h04, 1'b0);                       // 01 -> 00
        do_upd(8'h04, 1'b0);                       // 00 stays 00
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_nt4 got=%0b exp=0", pred_taken); end
        do_upd(8'h04, 1'b1);                       // 00 -> 01
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_floor_t got=%0b exp=0", pred_taken); end
        do_upd(8'h04, 1'b1);                       // 01 -> 10 proves it was 01
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_floor_t2 got=%0b exp=1", pred_taken); end
        do_upd(8'h04, 1'b0);                       // back to 01
    endtask

    task automatic test_hazard();
        req_valid = 1'b1; req_pc = 32'h0040_0010; history = 64'h0;
        upd_valid = 1'b1; upd_index = 8'h04; upd_taken = 1'b1;
        tick();
        req_valid = 1'b0; upd_valid = 1'b0;
        checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL hazard_valid got=%0b exp=1", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL hazard_old got=%0b exp=0", pred_taken); end
        do_req(32'h0040_0010, 64'h0);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL hazard_new got=%0b exp=1", pred_taken); end
    endtask

    task automatic test_idle();
        tick();
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL idle_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_index !== 8'h04) begin failures++; $display("FAIL idle_index_hold got=%0h exp=04", pred_index); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1;
        req_pc = 32'h0040_0010; history = 64'hFF; tick();
        checks++; if (pred_index !== 8'hFB) begin failures++; $display("FAIL b2b_0 got=%0h exp=fb", pred_index); end
        req_pc = 32'h0000_0040; history = 64'h0; tick();
        checks++; if (pred_index !== 8'h10) begin failures++; $display("FAIL b2b_1 got=%0h exp=10", pred_index); end
        req_pc = 32'h0040_0010; history = 64'h0; tick();
        checks++; if (pred_index !== 8'h04 || pred_taken !== 1'b1) begin
            failures++; $display("FAIL b2b_2 got=%0h/%0b exp=04/1", pred_index, pred_taken);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_upd(8'h20, 1'b1);                       // 01 -> 10
        do_upd(8'h20, 1'b1);                       // 10 -> 11
        do_req(32'h0000_0080, 64'h0);
        checks++; if (pred_taken !== 1'b1 || pred_index !== 8'h20) begin
            failures++; $display("FAIL midrst_trained got=%0h/%0b exp=20/1", pred_index, pred_taken);
        end
        rst = 1'b1; req_valid = 1'b1; req_pc = 32'h0000_0080; history = 64'h0;
        tick();
        rst = 1'b0; req_valid = 1'b0;
        checks++; if (ready !== 1'b0 || pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_index !== 8'h00) begin
            failures++; $display("FAIL midrst_outputs got=r%0b v%0b t%0b i%0h exp=r0 v0 t0 i0", ready, pred_valid, pred_taken, pred_index);
        end
        for (int k = 1; k <= 256; k++) begin
            tick();
            checks++;
            if (ready !== (k == 256)) begin
                failures++; $display("FAIL midrst_ready cycle=%0d got=%0b exp=%0b", k, ready, (k == 256));
            end
        end
        do_req(32'h0000_0080, 64'h0);
        checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
            failures++; $display("FAIL midrst_cleared got=v%0b t%0b exp=v1 t0", pred_valid, pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_init_timing();
        test_indexing();
        test_init_updates();
        test_saturation();
        test_hazard();
        test_idle();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
